// File: rtl/pwm_multi_pkg.sv
// Shared defaults and encodings for the multi-channel PWM block.
// Imported by the channel slice and by the top level.
package pwm_multi_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 16;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: period counter, shadowed settings, compare and registered output.
// state | meaning: IDLE = parked, output follows inv; RUN = counting with shadowed settings.
module pwm_chan
    import pwm_multi_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [CW-1:0] period,
    input  logic [CW-1:0] compare,
    input  logic          center,
    input  logic          inv,
    output logic          out,
    output logic          prd_end
);

    state_e        state, state_nxt;
    mode_e         ma, ma_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] pa, pa_nxt;
    logic [CW-1:0] ca, ca_nxt;
    logic          ia, ia_nxt;
    logic          down, down_nxt;
    logic          out_nxt;
    logic          last;

    // In center mode a period of 0 or 1 never enters the down phase.
    always_comb begin
        last = 1'b0;
        if (ma == EDGE)
            last = (cnt == pa);
        else if (down)
            last = (cnt == CW'(1));
        else
            last = (cnt == pa) && (pa <= CW'(1));
    end

    assign prd_end = (state == RUN) && last;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        down_nxt  = down;
        pa_nxt    = pa;
        ca_nxt    = ca;
        ma_nxt    = ma;
        ia_nxt    = ia;
        out_nxt   = (state == RUN) ? ((cnt < ca) ^ ia) : inv;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                down_nxt = 1'b0;
                if (en) begin
                    state_nxt = RUN;
                    pa_nxt    = period;
                    ca_nxt    = compare;
                    ma_nxt    = mode_e'(center);
                    ia_nxt    = inv;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    down_nxt  = 1'b0;
                end else if (last) begin
                    cnt_nxt  = '0;
                    down_nxt = 1'b0;
                    pa_nxt   = period;
                    ca_nxt   = compare;
                    ma_nxt   = mode_e'(center);
                    ia_nxt   = inv;
                end else if (ma == CENTER && !down && cnt == pa) begin
                    down_nxt = 1'b1;
                    cnt_nxt  = cnt - CW'(1);
                end else if (down) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            down  <= 1'b0;
            pa    <= '0;
            ca    <= '0;
            ma    <= EDGE;
            ia    <= 1'b0;
            out   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            down  <= down_nxt;
            pa    <= pa_nxt;
            ca    <= ca_nxt;
            ma    <= ma_nxt;
            ia    <= ia_nxt;
            out   <= out_nxt;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Bank of NCH independent PWM channels sharing one clock and reset.
// Each channel slices its period/compare fields from the packed input buses.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*CW-1:0] period,
    input  logic [NCH*CW-1:0] compare,
    input  logic [NCH-1:0]    center,
    input  logic [NCH-1:0]    inv,
    output logic [NCH-1:0]    out,
    output logic [NCH-1:0]    prd_end
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pwm_chan #(
            .CW(CW)
        ) u_chan (
            .clk     (mclk),
            .reset   (reset),
            .en      (en[i]),
            .period  (period[i*CW +: CW]),
            .compare (compare[i*CW +: CW]),
            .center  (center[i]),
            .inv     (inv[i]),
            .out     (out[i]),
            .prd_end (prd_end[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed and random stimulus for pwm_multi against a position-based reference model.
// Expected outputs are queued at drive time and compared one edge later.
module tb_pwm_multi;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic              mclk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    en;
    logic [NCH*CW-1:0] period;
    logic [NCH*CW-1:0] compare;
    logic [NCH-1:0]    center;
    logic [NCH-1:0]    inv;
    logic [NCH-1:0]    out;
    logic [NCH-1:0]    prd_end;

    pwm_multi #(.NCH(NCH), .CW(CW)) dut (
        .mclk    (mclk),
        .reset   (reset),
        .en      (en),
        .period  (period),
        .compare (compare),
        .center  (center),
        .inv     (inv),
        .out     (out),
        .prd_end (prd_end)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [NCH-1:0] o;
        logic [NCH-1:0] pe;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int m_run [NCH];
    int m_pos [NCH];
    int m_pa  [NCH];
    int m_ca  [NCH];
    int m_ma  [NCH];
    int m_ia  [NCH];

    // Reference: position within the period, converted to a counter value.
    function automatic int m_len(int i);
        if (m_ma[i] == 0) return m_pa[i] + 1;
        return (m_pa[i] == 0) ? 1 : 2 * m_pa[i];
    endfunction

    function automatic int m_cnt(int i);
        if (m_ma[i] == 0 || m_pos[i] <= m_pa[i]) return m_pos[i];
        return 2 * m_pa[i] - m_pos[i];
    endfunction

    task automatic m_load(int i);
        m_pa[i] = int'(period[i*CW +: CW]);
        m_ca[i] = int'(compare[i*CW +: CW]);
        m_ma[i] = int'(center[i]);
        m_ia[i] = int'(inv[i]);
        m_pos[i] = 0;
    endtask

    task automatic tick();
        exp_t e;
        exp_t got;
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                m_run[i] = 0; m_pos[i] = 0; m_pa[i] = 0;
                m_ca[i] = 0; m_ma[i] = 0; m_ia[i] = 0;
                e.o[i] = 1'b0;
            end else begin
                if (m_run[i] != 0)
                    e.o[i] = ((m_cnt(i) < m_ca[i]) != (m_ia[i] != 0));
                else
                    e.o[i] = inv[i];
                if (m_run[i] == 0) begin
                    if (en[i]) begin
                        m_run[i] = 1;
                        m_load(i);
                    end
                end else if (!en[i]) begin
                    m_run[i] = 0;
                    m_pos[i] = 0;
                end else if (m_pos[i] == m_len(i) - 1) begin
                    m_load(i);
                end else begin
                    m_pos[i]++;
                end
            end
            e.pe[i] = (m_run[i] != 0) && (m_pos[i] == m_len(i) - 1);
        end
        q.push_back(e);
        @(posedge mclk);
        #1;
        got = q.pop_front();
        checks++;
        assert (out === got.o) else begin
            errors++;
            $error("FAIL out observed=%b expected=%b t=%0t", out, got.o, $time);
        end
        checks++;
        assert (prd_end === got.pe) else begin
            errors++;
            $error("FAIL prd_end observed=%b expected=%b t=%0t", prd_end, got.pe, $time);
        end
    endtask

    task automatic set_ch(int i, int p, int c, int ctr, int iv);
        period[i*CW +: CW]  = CW'(p);
        compare[i*CW +: CW] = CW'(c);
        center[i] = ctr[0];
        inv[i]    = iv[0];
    endtask

    task automatic check_cnt(string tag, int obs, int expv);
        checks++;
        assert (obs == expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    int hi0, hi1, pe0, pe1;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_pa[i] = 0;
            m_ca[i] = 0; m_ma[i] = 0; m_ia[i] = 0;
        end
        reset = 1'b1; en = '0; period = '0; compare = '0; center = '0;
        inv = '1;
        #2;
        repeat (3) tick();
        check_cnt("reset_out", int'(out), 0);
        check_cnt("reset_prd_end", int'(prd_end), 0);

        // Idle channels register the live inv level.
        reset = 1'b0;
        inv = 4'b0101;
        repeat (2) tick();

        set_ch(0, 9, 3, 0, 0);
        set_ch(1, 4, 2, 1, 0);
        set_ch(2, 5, 6, 0, 1);
        set_ch(3, 7, 3, 1, 1);
        en = 4'b1111;
        hi0 = 0; hi1 = 0; pe0 = 0; pe1 = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            hi0 += int'(out[0]);
            hi1 += int'(out[1]);
            pe0 += int'(prd_end[0]);
            pe1 += int'(prd_end[1]);
        end
        check_cnt("edge_high_count", hi0, 12);
        check_cnt("edge_prd_end_count", pe0, 4);
        check_cnt("center_high_count", hi1, 14);
        check_cnt("center_prd_end_count", pe1, 5);

        // Mid-period compare change takes effect only at the next boundary.
        repeat (4) tick();
        set_ch(0, 9, 7, 0, 0);
        repeat (25) tick();

        set_ch(0, 9, 0, 0, 0);  repeat (22) tick();
        set_ch(0, 9, 0, 0, 1);  repeat (22) tick();
        set_ch(0, 9, 10, 0, 0); repeat (22) tick();
        set_ch(0, 9, 10, 0, 1); repeat (22) tick();
        set_ch(0, 9, 5, 0, 0);  repeat (12) tick();

        // Drop enable mid-period, then pulse reset while others run.
        set_ch(0, 9, 3, 0, 1);
        repeat (6) tick();
        en[0] = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        en[0] = 1'b1;
        repeat (20) tick();

        // Center mode short periods and reload coinciding with disable.
        set_ch(1, 1, 1, 1, 0);
        set_ch(2, 0, 1, 1, 0);
        set_ch(3, 0, 0, 0, 1);
        repeat (20) tick();

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                int ch;
                ch = $urandom_range(0, NCH - 1);
                set_ch(ch, $urandom_range(0, 12), $urandom_range(0, 14),
                       $urandom_range(0, 1), $urandom_range(0, 1));
            end
            if ($urandom_range(0, 29) == 0)
                en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
